pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It sequences the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers, and drives their enable and clear inputs (IF/ID en and IntBeq flush).
- Detects data hazards that cannot be resolved by forwarding.
- Tracks the multi-cycle mult/div unit with an internal busy counter.
- Runs the interrupt-entry sequence that drains and flushes the pipeline before the PC is redirected to the handler.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_hazard_ctrl_if.sv | 52 +++++
 rtl/md_busy_cnt.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: Tuse/Tnew
// encodings, interrupt-entry FSM states, default MDU latencies and the
// per-source data-hazard test.
package pipe_pkg;

    // Tuse/Tnew encodings: stage in which an operand is needed / produced.
    localparam logic [1:0] TUSE_ID   = 2'd0;
    localparam logic [1:0] TUSE_EX   = 2'd1;
    localparam logic [1:0] TUSE_MEM  = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Default number of EX cycles the MDU stays busy after a start.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Interrupt-entry sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_MD = 2'd1,
        ST_ENTER   = 2'd2
    } irq_state_t;

    // A source needs a stall when a younger-than-forwardable producer in EX
    // or MEM writes it and the consumer needs it before the value exists.
    // Register 0 never hazards; TUSE_NONE marks an unused source.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] ex_wa,
        input logic [1:0] ex_tnew,
        input logic [4:0] mem_wa,
        input logic [1:0] mem_tnew
    );
        return (src != 5'd0) && (tuse != TUSE_NONE) &&
               (((src == ex_wa)  && (tuse < ex_tnew)) ||
                ((src == mem_wa) && (tuse < mem_tnew)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of the hazard controller's decode/pipeline inputs and its
// enable/clear outputs. The controller uses the slave modport; the
// pipeline side (or a bench) uses master.
// Optional: HAZARD_STATS_EN adds the stall_cnt statistics output.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [1:0]  id_tuse_rs;
    logic [1:0]  id_tuse_rt;
    logic        id_md;
    logic [4:0]  ex_wa;
    logic [1:0]  ex_tnew;
    logic [4:0]  mem_wa;
    logic [1:0]  mem_tnew;
    logic        ex_md_start;
    logic        ex_md_is_div;
    logic        irq;
    logic        int_en;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_clr;
    logic        exmem_clr;
    logic        epc_we;
    logic        pc_sel_exc;
    logic        md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    modport master (
        output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md,
        output ex_wa, ex_tnew, mem_wa, mem_tnew,
        output ex_md_start, ex_md_is_div, irq, int_en,
        input  pc_en, ifid_en, ifid_flush, idex_clr, exmem_clr,
        input  epc_we, pc_sel_exc, md_busy
`ifdef HAZARD_STATS_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md,
        input  ex_wa, ex_tnew, mem_wa, mem_tnew,
        input  ex_md_start, ex_md_is_div, irq, int_en,
        output pc_en, ifid_en, ifid_flush, idex_clr, exmem_clr,
        output epc_we, pc_sel_exc, md_busy
`ifdef HAZARD_STATS_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/md_busy_cnt.sv
// Mult/div unit busy tracker: loads the operation latency on a start,
// counts down to zero, and reports busy while non-zero. A start while
// busy reloads the counter so the most recent operation wins.
module md_busy_cnt #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic md_busy
);

    logic [CNT_W-1:0] cnt_reg;

    // Load on start, otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (start) begin
            cnt_reg <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign md_busy = (cnt_reg != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: data-hazard
// and MDU stalls, plus the interrupt-entry sequence that waits for the
// MDU, then flushes the pipe and redirects the PC in a single cycle.
// All outputs are combinational from state, the MDU counter and inputs.
// Optional: define HAZARD_STATS_EN for a saturating frozen-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    irq_state_t state_reg;
    irq_state_t state_next;
    logic       md_busy;
    logic       stall_d;
    logic       stall_m;
    logic       stall;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_clr;
    logic       exmem_clr;
    logic       epc_we;
    logic       pc_sel_exc;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk     (clk),
        .rst     (rst),
        .start   (hz.ex_md_start),
        .is_div  (hz.ex_md_is_div),
        .md_busy (md_busy)
    );

    // An MDU instruction in ID must also wait for an op starting this cycle.
    assign stall_d = src_hazard(hz.id_rs, hz.id_tuse_rs, hz.ex_wa, hz.ex_tnew,
                                hz.mem_wa, hz.mem_tnew) |
                     src_hazard(hz.id_rt, hz.id_tuse_rt, hz.ex_wa, hz.ex_tnew,
                                hz.mem_wa, hz.mem_tnew);
    assign stall_m = hz.id_md & (md_busy | hz.ex_md_start);
    assign stall   = stall_d | stall_m;

    // Interrupt sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and pipeline controls; ENTER beats WAIT_MD beats stall,
    // and reset overrides everything.
    always_comb begin
        state_next = state_reg;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_clr   = 1'b0;
        exmem_clr  = 1'b0;
        epc_we     = 1'b0;
        pc_sel_exc = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (hz.irq && hz.int_en) begin
                    state_next = (md_busy || hz.ex_md_start) ? ST_WAIT_MD : ST_ENTER;
                end
                if (stall) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_clr = 1'b1;
                end
            end
            ST_WAIT_MD: begin
                // Request is latched here; irq/int_en no longer matter.
                if (!md_busy) begin
                    state_next = ST_ENTER;
                end
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_clr = 1'b1;
            end
            ST_ENTER: begin
                state_next = ST_IDLE;
                ifid_flush = 1'b1;
                idex_clr   = 1'b1;
                exmem_clr  = 1'b1;
                epc_we     = 1'b1;
                pc_sel_exc = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
            idex_clr   = 1'b1;
            exmem_clr  = 1'b0;
            epc_we     = 1'b0;
            pc_sel_exc = 1'b0;
        end
    end

    assign hz.pc_en      = pc_en;
    assign hz.ifid_en    = ifid_en;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_clr   = idex_clr;
    assign hz.exmem_clr  = exmem_clr;
    assign hz.epc_we     = epc_we;
    assign hz.pc_sel_exc = pc_sel_exc;
    assign hz.md_busy    = md_busy & ~rst;

`ifdef HAZARD_STATS_EN
    logic        front_freeze;
    logic [31:0] stall_cnt_reg;

    assign front_freeze = (state_reg == ST_WAIT_MD) || ((state_reg == ST_IDLE) && stall);

    // Count frozen front-end cycles, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= 32'd0;
        end else if (front_freeze && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: reset checks, a table of single-cycle
// hazard vectors, hand-written multi-cycle sequences (MDU stall,
// interrupt entry, async reset in WAIT_MD) and randomized stimulus
// against a behavioural model. Output bit order in messages:
// {pc_en, ifid_en, ifid_flush, idex_clr, exmem_clr, epc_we, pc_sel_exc, md_busy}.
module tb_pipe_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam logic [7:0] O_NORM = 8'b1100_0000;
    localparam logic [7:0] O_FRZ  = 8'b0001_0000;
    localparam logic [7:0] O_ENT  = 8'b1111_1110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] tu_rs, tu_rt;
        logic       md;
        logic [4:0] ewa;
        logic [1:0] etn;
        logic [4:0] mwa;
        logic [1:0] mtn;
        logic       st, dv, irq, ie;
    } in_t;

    typedef struct {
        in_t        v;
        logic [7:0] exp;
        string      name;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: cycles of MDU work left, a pending interrupt
    // waiting for the MDU, and whether this cycle is the entry cycle.
    int          m_busy_left = 0;
    bit          m_waiting   = 0;
    bit          m_entering  = 0;
    longint      m_frz       = 0;

    function automatic in_t idle_in();
        in_t v;
        v.rs = 0; v.rt = 0; v.tu_rs = 2'd3; v.tu_rt = 2'd3; v.md = 0;
        v.ewa = 0; v.etn = 0; v.mwa = 0; v.mtn = 0;
        v.st = 0; v.dv = 0; v.irq = 0; v.ie = 0;
        return v;
    endfunction

    function automatic in_t mk(logic [4:0] rs, logic [1:0] tu_rs, logic [4:0] rt,
                               logic [1:0] tu_rt, logic [4:0] ewa, logic [1:0] etn,
                               logic [4:0] mwa, logic [1:0] mtn, logic md);
        in_t v = idle_in();
        v.rs = rs; v.tu_rs = tu_rs; v.rt = rt; v.tu_rt = tu_rt;
        v.ewa = ewa; v.etn = etn; v.mwa = mwa; v.mtn = mtn; v.md = md;
        return v;
    endfunction

    function automatic bit needs_wait(logic [4:0] s, logic [1:0] tu, in_t v);
        if (s == 0 || tu == 2'd3) return 0;
        if (s == v.ewa && int'(tu) < int'(v.etn)) return 1;
        if (s == v.mwa && int'(tu) < int'(v.mtn)) return 1;
        return 0;
    endfunction

    function automatic logic [7:0] model_out(in_t v);
        bit busy;
        bit hold;
        if (rst) return O_FRZ;
        busy = (m_busy_left > 0);
        if (m_entering) return O_ENT | {7'b0, busy};
        if (m_waiting)  return O_FRZ | {7'b0, busy};
        hold = needs_wait(v.rs, v.tu_rs, v) || needs_wait(v.rt, v.tu_rt, v) ||
               (v.md && (busy || v.st));
        return (hold ? O_FRZ : O_NORM) | {7'b0, busy};
    endfunction

    task automatic model_reset();
        m_busy_left = 0; m_waiting = 0; m_entering = 0; m_frz = 0;
    endtask

    task automatic model_step(in_t v);
        logic [7:0] o;
        bit busy;
        if (rst) begin
            model_reset();
            return;
        end
        o = model_out(v);
        if (!o[7] && m_frz < 64'hFFFF_FFFF) m_frz++;
        busy = (m_busy_left > 0);
        if (m_entering) begin
            m_entering = 0;
        end else if (m_waiting) begin
            if (!busy) begin m_waiting = 0; m_entering = 1; end
        end else if (v.irq && v.ie) begin
            if (busy || v.st) m_waiting = 1; else m_entering = 1;
        end
        if (v.st) m_busy_left = v.dv ? DIV_N : MULT_N;
        else if (busy) m_busy_left--;
    endtask

    function automatic logic [7:0] outvec();
        return {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_clr,
                hz.exmem_clr, hz.epc_we, hz.pc_sel_exc, hz.md_busy};
    endfunction

    task automatic check8(string name, logic [7:0] got, logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: outputs %b, expected %b", name, got, exp);
    endtask

    task automatic drive(in_t v);
        hz.id_rs = v.rs; hz.id_rt = v.rt;
        hz.id_tuse_rs = v.tu_rs; hz.id_tuse_rt = v.tu_rt; hz.id_md = v.md;
        hz.ex_wa = v.ewa; hz.ex_tnew = v.etn; hz.mem_wa = v.mwa; hz.mem_tnew = v.mtn;
        hz.ex_md_start = v.st; hz.ex_md_is_div = v.dv;
        hz.irq = v.irq; hz.int_en = v.ie;
    endtask

    // One clock cycle: drive at negedge, check mid-low phase, advance model.
    task automatic apply(in_t v, logic r, bit use_tab, logic [7:0] tab, string name);
        logic [7:0] exp;
        @(negedge clk);
        rst = r;
        drive(v);
        #1;
        exp = use_tab ? tab : model_out(v);
        check8(name, outvec(), exp);
`ifdef HAZARD_STATS_EN
        n_chk++;
        if (hz.stall_cnt === 32'(m_frz)) n_pass++;
        else $display("FAIL %s_stall_cnt: got %0d, expected %0d", name, hz.stall_cnt, m_frz);
`endif
        $display("cyc %s rst=%0b out=%b exp=%b", name, r, outvec(), exp);
        model_step(v);
    endtask

    vec_t vq[$];

    task automatic add(string name, in_t v, logic [7:0] exp);
        vec_t t;
        t.v = v; t.exp = exp; t.name = name;
        vq.push_back(t);
    endtask

    initial begin
        in_t v;
        // Single-cycle hazard vectors: MDU idle, FSM idle.
        add("ld_use_ex",    mk(5'd5, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2, 5'd0, 2'd0, 0), O_FRZ);
        add("ex_tnew_eq",   mk(5'd5, 2'd1, 5'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, 0), O_NORM);
        add("mem_ready",    mk(5'd5, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 5'd5, 2'd0, 0), O_NORM);
        add("mem_late",     mk(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 5'd5, 2'd1, 0), O_FRZ);
        add("zero_reg",     mk(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 0), O_NORM);
        add("tuse_none",    mk(5'd7, 2'd3, 5'd0, 2'd3, 5'd7, 2'd2, 5'd0, 2'd0, 0), O_NORM);
        add("rt_ex",        mk(5'd0, 2'd3, 5'd9, 2'd0, 5'd9, 2'd1, 5'd0, 2'd0, 0), O_FRZ);
        add("rt_tnew3",     mk(5'd0, 2'd3, 5'd9, 2'd2, 5'd9, 2'd3, 5'd0, 2'd0, 0), O_FRZ);
        add("no_match",     mk(5'd3, 2'd0, 5'd4, 2'd0, 5'd6, 2'd2, 5'd8, 2'd1, 0), O_NORM);
        add("md_idle",      mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1), O_NORM);

        drive(idle_in());
        // Reset state.
        apply(idle_in(), 1'b1, 1, O_FRZ, "reset0");
        apply(idle_in(), 1'b1, 1, O_FRZ, "reset1");
        apply(idle_in(), 1'b0, 1, O_NORM, "post_reset");

        foreach (vq[i]) apply(vq[i].v, 1'b0, 1, vq[i].exp, vq[i].name);

        // Divide start with an MDU instruction held in ID: 11 stalled cycles.
        v = idle_in(); v.md = 1; v.st = 1; v.dv = 1;
        apply(v, 1'b0, 1, O_FRZ, "div_start");
        v.st = 0;
        for (int i = 1; i <= DIV_N; i++) apply(v, 1'b0, 1, O_FRZ | 8'd1, "div_busy");
        apply(v, 1'b0, 1, O_NORM, "div_release");

        // Masked request does nothing; enabled request enters next cycle.
        v = idle_in(); v.irq = 1; v.ie = 0;
        apply(v, 1'b0, 1, O_NORM, "irq_masked");
        apply(idle_in(), 1'b0, 1, O_NORM, "irq_masked_next");
        v.ie = 1;
        apply(v, 1'b0, 1, O_NORM, "irq_req");
        apply(idle_in(), 1'b0, 1, O_ENT, "irq_enter");
        apply(idle_in(), 1'b0, 1, O_NORM, "irq_done");

        // Interrupt during a multiply: wait for the MDU, then enter once.
        v = idle_in(); v.st = 1;
        apply(v, 1'b0, 1, O_NORM, "mul_start");
        v = idle_in(); v.irq = 1; v.ie = 1;
        apply(v, 1'b0, 1, O_NORM | 8'd1, "mul_irq");
        for (int i = 0; i < MULT_N - 1; i++) apply(idle_in(), 1'b0, 1, O_FRZ | 8'd1, "wait_busy");
        apply(idle_in(), 1'b0, 1, O_FRZ, "wait_last");
        apply(idle_in(), 1'b0, 1, O_ENT, "mul_enter");
        apply(idle_in(), 1'b0, 1, O_NORM, "mul_done");

        // Asynchronous reset while waiting for a divide.
        v = idle_in(); v.st = 1; v.dv = 1;
        apply(v, 1'b0, 1, O_NORM, "rdiv_start");
        v = idle_in(); v.irq = 1; v.ie = 1;
        apply(v, 1'b0, 1, O_NORM | 8'd1, "rdiv_irq");
        apply(idle_in(), 1'b0, 1, O_FRZ | 8'd1, "rdiv_wait");
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check8("async_rst", outvec(), O_FRZ);
        $display("cyc async_rst out=%b", outvec());
        model_reset();
        apply(idle_in(), 1'b1, 1, O_FRZ, "rst_hold");
        for (int i = 0; i < 12; i++) apply(idle_in(), 1'b0, 1, O_NORM, "no_epc_after_rst");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            v.rs = 5'($urandom_range(0, 3));  v.rt = 5'($urandom_range(0, 3));
            v.tu_rs = 2'($urandom_range(0, 3)); v.tu_rt = 2'($urandom_range(0, 3));
            v.ewa = 5'($urandom_range(0, 3)); v.etn = 2'($urandom_range(0, 3));
            v.mwa = 5'($urandom_range(0, 3)); v.mtn = 2'($urandom_range(0, 3));
            v.md  = ($urandom_range(0, 3) == 0);
            v.st  = ($urandom_range(0, 9) == 0);
            v.dv  = 1'($urandom_range(0, 1));
            v.irq = ($urandom_range(0, 19) == 0);
            v.ie  = 1'($urandom_range(0, 1));
            apply(v, ($urandom_range(0, 149) == 0), 0, 8'd0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
